// File: rtl/decode_stage.sv
// ProtoCore decode stage: registered control bundle with valid/ready handshakes, flush and sticky halt.
// Optional load-use interlock and stall counter enabled by DECODE_LOAD_INTERLOCK_EN.
module decode_stage #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [4+3*REG_ADDR_W+DATA_W-1:0]       instruction,
  input  logic                                   flush,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   write_alu,
  output logic                                   write_en,
  output logic                                   ram_write_en,
  output logic                                   imm_flag,
  output logic                                   is_load,
  output logic                                   is_jump,
  output logic                                   is_beq,
  output logic                                   is_bne,
  output logic                                   halt,
  output logic [2:0]                             alu_opcode,
  output logic [DATA_W-1:0]                      imm_value,
  output logic [REG_ADDR_W-1:0]                  ra_addr,
  output logic [REG_ADDR_W-1:0]                  rb_addr,
  output logic [REG_ADDR_W-1:0]                  write_addr,
  output logic                                   halted,
  output logic [15:0]                            stall_cnt
);
  localparam int INSTR_W = 4 + 3*REG_ADDR_W + DATA_W;

  typedef enum logic {RUN, HALTED} state_t;
  state_t state_reg;

  logic [3:0]            op;
  logic [REG_ADDR_W-1:0] f_ra, f_rb, f_rd;
  logic [DATA_W-1:0]     f_data;

  assign op     = instruction[INSTR_W-1 -: 4];
  assign f_ra   = instruction[DATA_W+2*REG_ADDR_W +: REG_ADDR_W];
  assign f_rb   = instruction[DATA_W+REG_ADDR_W +: REG_ADDR_W];
  assign f_rd   = instruction[DATA_W +: REG_ADDR_W];
  assign f_data = instruction[DATA_W-1:0];

  logic                  d_write_alu, d_write_en, d_ram_write_en, d_imm_flag;
  logic                  d_is_load, d_is_jump, d_is_beq, d_is_bne, d_halt;
  logic [2:0]            d_alu_opcode;
  logic [DATA_W-1:0]     d_imm_value;
  logic [REG_ADDR_W-1:0] d_ra, d_rb, d_wa;

  always_comb begin
    d_write_alu    = 1'b0;
    d_write_en     = 1'b0;
    d_ram_write_en = 1'b0;
    d_imm_flag     = 1'b0;
    d_is_load      = 1'b0;
    d_is_jump      = 1'b0;
    d_is_beq       = 1'b0;
    d_is_bne       = 1'b0;
    d_halt         = 1'b0;
    d_alu_opcode   = 3'd0;
    d_imm_value    = '0;
    d_ra           = '0;
    d_rb           = '0;
    d_wa           = '0;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
        d_write_alu  = 1'b1;
        d_write_en   = 1'b1;
        d_alu_opcode = op[2:0];
        d_ra         = f_ra;
        d_rb         = f_rb;
        d_wa         = f_rd;
      end
      4'h5, 4'h6, 4'h7: begin
        d_write_alu  = 1'b1;
        d_write_en   = 1'b1;
        d_alu_opcode = op[2:0];
        d_ra         = f_ra;
        d_wa         = f_rd;
      end
      4'h8, 4'h9: begin
        // immediate ALU ops take their destination from the rb field
        d_write_alu  = 1'b1;
        d_write_en   = 1'b1;
        d_imm_flag   = 1'b1;
        d_alu_opcode = {2'b00, op[0]};
        d_ra         = f_ra;
        d_wa         = f_rb;
        d_imm_value  = f_data;
      end
      4'hA: begin
        d_write_en  = 1'b1;
        d_is_load   = 1'b1;
        d_imm_flag  = 1'b1;
        d_ra        = f_ra;
        d_wa        = f_rd;
        d_imm_value = f_data;
      end
      4'hB: begin
        d_ram_write_en = 1'b1;
        d_imm_flag     = 1'b1;
        d_ra           = f_ra;
        d_rb           = f_rb;
        d_imm_value    = f_data;
      end
      4'hC, 4'hD: begin
        d_is_beq     = (op == 4'hC);
        d_is_bne     = (op == 4'hD);
        d_alu_opcode = 3'd1;
        d_ra         = f_ra;
        d_rb         = f_rb;
        d_imm_value  = f_data;
      end
      4'hE: begin
        d_is_jump   = 1'b1;
        d_ra        = f_ra;
        d_imm_value = f_data;
      end
      default: begin
        d_halt      = 1'b1;
        d_imm_value = f_data;
      end
    endcase
  end

  logic hazard, accept;

`ifdef DECODE_LOAD_INTERLOCK_EN
  logic reads_ra, reads_rb;
  assign reads_ra = (op != 4'hF);
  assign reads_rb = (op <= 4'h4) || (op == 4'hB) || (op == 4'hC) || (op == 4'hD);
  assign hazard   = in_valid && out_valid && is_load &&
                    ((reads_ra && (f_ra == write_addr)) || (reads_rb && (f_rb == write_addr)));
`else
  assign hazard = 1'b0;
`endif

  assign in_ready = !flush && (state_reg == RUN) && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign halted   = (state_reg == HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      out_valid    <= 1'b0;
      write_alu    <= 1'b0;
      write_en     <= 1'b0;
      ram_write_en <= 1'b0;
      imm_flag     <= 1'b0;
      is_load      <= 1'b0;
      is_jump      <= 1'b0;
      is_beq       <= 1'b0;
      is_bne       <= 1'b0;
      halt         <= 1'b0;
      alu_opcode   <= 3'd0;
      imm_value    <= '0;
      ra_addr      <= '0;
      rb_addr      <= '0;
      write_addr   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      state_reg <= RUN;
    end else if (accept) begin
      out_valid    <= 1'b1;
      write_alu    <= d_write_alu;
      write_en     <= d_write_en;
      ram_write_en <= d_ram_write_en;
      imm_flag     <= d_imm_flag;
      is_load      <= d_is_load;
      is_jump      <= d_is_jump;
      is_beq       <= d_is_beq;
      is_bne       <= d_is_bne;
      halt         <= d_halt;
      alu_opcode   <= d_alu_opcode;
      imm_value    <= d_imm_value;
      ra_addr      <= d_ra;
      rb_addr      <= d_rb;
      write_addr   <= d_wa;
      if (d_halt) state_reg <= HALTED;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DECODE_LOAD_INTERLOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if (hazard && (state_reg == RUN) && !flush && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = 16'd0;
`endif

endmodule
